// File: rtl/intra_dc_sched_if.sv
// Control/handshake bundle between the DC intra sequencer and its neighbours:
// frame start/status, datapath control, neighbour fetch and prediction buffer.
interface intra_dc_sched_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [9:0] blk_x;
    logic [9:0] blk_y;
    logic       haveLeft;
    logic       haveAbove;
    logic [9:0] w;
    logic [9:0] h;
    logic [9:0] log2W;
    logic [9:0] log2H;
    logic       nb_req;
    logic       nb_ack;
    logic       pb_valid;
    logic       pb_ready;

    modport master (
        input  start, nb_ack, pb_ready,
        output busy, done, blk_x, blk_y, haveLeft, haveAbove,
               w, h, log2W, log2H, nb_req, pb_valid
    );

    modport slave (
        output start, nb_ack, pb_ready,
        input  busy, done, blk_x, blk_y, haveLeft, haveAbove,
               w, h, log2W, log2H, nb_req, pb_valid
    );
endinterface

// File: rtl/intra_dc_sched.sv
// Raster-order sequencer for the DC intra-prediction datapath: one 4x4 block
// in flight, neighbour fetch -> fixed-latency predict -> buffer handshake.
module intra_dc_sched #(
    parameter int FRAME_W_BLK = 4,
    parameter int FRAME_H_BLK = 4,
    parameter int PRED_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    intra_dc_sched_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PREDICT, S_WRITE, S_ADVANCE, S_DONE
    } state_e;

    localparam logic [9:0] LAST_X = 10'(FRAME_W_BLK - 1);
    localparam logic [9:0] LAST_Y = 10'(FRAME_H_BLK - 1);
    localparam logic [3:0] LAT    = 4'(PRED_LAT);

    state_e     state_q, state_d;
    logic [9:0] blk_x_q, blk_x_d;
    logic [9:0] blk_y_q, blk_y_d;
    logic       have_left_q, have_left_d;
    logic       have_above_q, have_above_d;
    logic [3:0] lat_cnt_q, lat_cnt_d;
    logic       has_nb;

    assign has_nb = have_left_q | have_above_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            blk_x_q      <= '0;
            blk_y_q      <= '0;
            have_left_q  <= 1'b0;
            have_above_q <= 1'b0;
            lat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            blk_x_q      <= blk_x_d;
            blk_y_q      <= blk_y_d;
            have_left_q  <= have_left_d;
            have_above_q <= have_above_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        blk_x_d      = blk_x_q;
        blk_y_d      = blk_y_q;
        have_left_d  = have_left_q;
        have_above_d = have_above_q;
        lat_cnt_d    = lat_cnt_q;
        case (state_q)
            S_IDLE: begin
                blk_x_d      = '0;
                blk_y_d      = '0;
                have_left_d  = 1'b0;
                have_above_d = 1'b0;
                if (bus.start) state_d = S_FETCH;
            end
            // Block (0,0) has no neighbours; the datapath falls back to mid-grey.
            S_FETCH: begin
                if (!has_nb || bus.nb_ack) begin
                    state_d   = S_PREDICT;
                    lat_cnt_d = LAT;
                end
            end
            S_PREDICT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.pb_ready) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (blk_x_q == LAST_X && blk_y_q == LAST_Y) begin
                    state_d = S_DONE;
                end else if (blk_x_q == LAST_X) begin
                    state_d      = S_FETCH;
                    blk_x_d      = '0;
                    blk_y_d      = blk_y_q + 10'd1;
                    have_left_d  = 1'b0;
                    have_above_d = 1'b1;
                end else begin
                    state_d     = S_FETCH;
                    blk_x_d     = blk_x_q + 10'd1;
                    have_left_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.blk_x     = blk_x_q;
    assign bus.blk_y     = blk_y_q;
    assign bus.haveLeft  = have_left_q;
    assign bus.haveAbove = have_above_q;
    assign bus.w         = 10'd4;
    assign bus.h         = 10'd4;
    assign bus.log2W     = 10'd2;
    assign bus.log2H     = 10'd2;
    // Fetch unit keeps neighbour pixels stable until the block is accepted.
    assign bus.nb_req    = has_nb && (state_q == S_FETCH || state_q == S_PREDICT ||
                                      state_q == S_WRITE);
    assign bus.pb_valid  = (state_q == S_WRITE);
endmodule

// File: tb/tb_intra_dc_sched.sv
// Directed bench for intra_dc_sched: 2x2, 1x1 and 4x4 frames with fetch/buffer
// models, stalls, stray inputs and mid-frame reset.
module tb_intra_dc_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    intra_dc_sched_if ia();
    intra_dc_sched_if ib();
    intra_dc_sched_if ic();

    intra_dc_sched #(.FRAME_W_BLK(2), .FRAME_H_BLK(2), .PRED_LAT(1))
        u_a (.clk(clk), .rst(rst), .bus(ia.master));
    intra_dc_sched #(.FRAME_W_BLK(1), .FRAME_H_BLK(1), .PRED_LAT(1))
        u_b (.clk(clk), .rst(rst), .bus(ib.master));
    intra_dc_sched #(.FRAME_W_BLK(4), .FRAME_H_BLK(4), .PRED_LAT(2))
        u_c (.clk(clk), .rst(rst), .bus(ic.master));

    int n_chk  = 0;
    int n_fail = 0;

    // {x, y, haveLeft, haveAbove} for the 2x2 frame in raster order
    logic [3:0] exp_blk [4] = '{4'b0000, 4'b1010, 4'b0101, 4'b1111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input int ack_blk, input int ack_dly, input int rdy_blk,
                         input int rdy_stall, input bit stray, input int exp_done,
                         input string nm);
        int nwr = 0, req_cnt = 0, vcnt = 0, nreq_v = 0, stall_v = 0;
        int ack_k = 0, rise_k = 0, done_k = 0, n_done = 0, n_req00 = 0, n_coord = 0;
        int busy_after = 1;
        bit held = 0, pv_prev = 0;
        logic [9:0] hx = '0, hy = '0;
        ia.start = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step();
            ia.start = stray ? ia.busy : 1'b0;
            if (ia.nb_req || ia.pb_valid) begin
                if (held && (ia.blk_x != hx || ia.blk_y != hy)) n_coord++;
                hx = ia.blk_x; hy = ia.blk_y; held = 1;
            end else begin
                held = 0;
            end
            if (ia.nb_req && ia.blk_x == 0 && ia.blk_y == 0) n_req00++;
            if (ia.nb_req) req_cnt++; else req_cnt = 0;
            ia.nb_ack = ia.nb_req && (req_cnt == ((nwr == ack_blk) ? ack_dly : 0) + 1);
            if (ia.nb_ack && nwr == ack_blk) ack_k = k;
            if (stray && ia.nb_req && (req_cnt == 2 || req_cnt == 3)) ia.nb_ack = 1'b1;
            if (ia.pb_valid && !pv_prev && nwr == ack_blk) rise_k = k;
            pv_prev = ia.pb_valid;
            if (ia.pb_valid) begin
                vcnt++;
                if (nwr == rdy_blk && ia.nb_req) nreq_v++;
                ia.pb_ready = (vcnt > ((nwr == rdy_blk) ? rdy_stall : 0));
            end else begin
                ia.pb_ready = stray && ia.busy;
            end
            if (ia.pb_valid && ia.pb_ready) begin
                if (nwr < 4)
                    chk($sformatf("%s_blk%0d", nm, nwr),
                        {ia.blk_x, ia.blk_y, ia.haveLeft, ia.haveAbove},
                        {9'b0, exp_blk[nwr][3], 9'b0, exp_blk[nwr][2],
                         exp_blk[nwr][1], exp_blk[nwr][0]});
                if (nwr == rdy_blk) stall_v = vcnt;
                nwr++;
                vcnt = 0;
            end
            if (ia.done) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
            if (done_k != 0 && k == done_k + 1) busy_after = ia.busy;
            if (done_k != 0 && k >= done_k + 3) break;
        end
        ia.start = 1'b0; ia.nb_ack = 1'b0; ia.pb_ready = 1'b0;
        chk({nm, "_nwr"}, nwr, 4);
        chk({nm, "_done_cyc"}, done_k, exp_done);
        chk({nm, "_ndone"}, n_done, 1);
        chk({nm, "_req00"}, n_req00, 0);
        chk({nm, "_coord_hold"}, n_coord, 0);
        chk({nm, "_busy_after"}, busy_after, 0);
        if (ack_dly > 0) chk({nm, "_ack2valid"}, rise_k - ack_k, 2);
        if (rdy_stall > 0) begin
            chk({nm, "_valid_cycles"}, stall_v, rdy_stall + 1);
            chk({nm, "_nbreq_cycles"}, nreq_v, rdy_stall + 1);
        end
    endtask

    initial begin
        int nwr, nreq, wk, dk, rc;
        logic busy1, busy6, hit;
        logic [1:0] hlha;
        ia.start = 0; ia.nb_ack = 0; ia.pb_ready = 0;
        ib.start = 0; ib.nb_ack = 0; ib.pb_ready = 0;
        ic.start = 0; ic.nb_ack = 0; ic.pb_ready = 0;
        step(); step();
        chk("rst_outs", {ia.busy, ia.done, ia.nb_req, ia.pb_valid, ia.haveLeft,
                         ia.haveAbove, ia.blk_x, ia.blk_y}, 32'd0);
        chk("rst_wh", {ia.w, ia.h}, {10'd4, 10'd4});
        chk("rst_log2", {ia.log2W, ia.log2H}, {10'd2, 10'd2});
        rst = 1'b0;
        step();

        run_a(-1, 0, -1, 0, 1'b0, 17, "base");
        run_a(1, 7, -1, 0, 1'b0, 24, "ackdly");
        run_a(-1, 0, 2, 5, 1'b0, 22, "stall");
        run_a(-1, 0, -1, 0, 1'b1, 17, "stray");

        // 1x1 frame
        nwr = 0; nreq = 0; wk = 0; dk = 0; busy1 = 0; busy6 = 1; hlha = 2'b11;
        ib.start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            ib.start = 1'b0;
            ib.pb_ready = 1'b1;
            if (ib.nb_req) nreq++;
            if (ib.pb_valid && ib.pb_ready) begin
                nwr++; wk = k; hlha = {ib.haveLeft, ib.haveAbove};
            end
            if (ib.done && dk == 0) dk = k;
            if (k == 1) busy1 = ib.busy;
            if (k == 6) busy6 = ib.busy;
        end
        ib.pb_ready = 1'b0;
        chk("f1_nwr", nwr, 1);
        chk("f1_write_cyc", wk, 3);
        chk("f1_hlha", hlha, 2'b00);
        chk("f1_nbreq", nreq, 0);
        chk("f1_done_cyc", dk, 5);
        chk("f1_busy1", busy1, 1);
        chk("f1_busy6", busy6, 0);

        // 4x4 frame, reset in first PREDICT cycle of block (1,1)
        rc = 0; hit = 0;
        ic.start = 1'b1;
        for (int k = 1; k <= 200 && !hit; k++) begin
            step();
            ic.start = 1'b0;
            if (ic.nb_req) rc++; else rc = 0;
            ic.nb_ack = ic.nb_req && rc == 1;
            ic.pb_ready = 1'b1;
            if (ic.blk_x == 1 && ic.blk_y == 1 && rc == 2 && !ic.pb_valid) begin
                rst = 1'b1; hit = 1;
            end
        end
        ic.nb_ack = 1'b0; ic.pb_ready = 1'b0;
        chk("f4_rst_hit", hit, 1);
        step();
        chk("f4_rst_outs", {ic.busy, ic.done, ic.nb_req, ic.pb_valid, ic.haveLeft,
                            ic.haveAbove, ic.blk_x, ic.blk_y}, 32'd0);
        chk("f4_rst_wh", {ic.w, ic.h}, {10'd4, 10'd4});
        chk("f4_rst_log2", {ic.log2W, ic.log2H}, {10'd2, 10'd2});
        step();
        rst = 1'b0;
        step();
        ic.start = 1'b1;
        ic.pb_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            ic.start = 1'b0;
            if (k == 1)
                chk("f4_restart", {ic.busy, ic.nb_req, ic.blk_x, ic.blk_y}, {2'b10, 20'd0});
            if (k == 3) chk("f4_pv_early", ic.pb_valid, 0);
            if (k == 4)
                chk("f4_first_wr", {ic.pb_valid, ic.blk_x, ic.blk_y}, {1'b1, 20'd0});
        end
        ic.pb_ready = 1'b0;
        rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/intra_dc_sched.md
# intra_dc_sched

Sequencing controller for the DC intra-prediction datapath. It walks a frame of 4x4 macroblocks in raster order and derives neighbour availability from each block's position. It requests neighbour pixels from the neighbour fetch unit, waits the datapath's fixed prediction latency, and hands each predicted block to the prediction buffer with a valid/ready handshake. Only one block is in flight at a time; the controller is the sole driver of the datapath's control inputs.

## Interface
- FRAME_W_BLK, 4, frame width in 4x4 blocks (1..1023)
- FRAME_H_BLK, 4, frame height in 4x4 blocks (1..1023)
- PRED_LAT, 1, cycles from stable datapath inputs to valid registered `pred` (1..15)

- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last block's write handshake
- blk_x  out  10  current block column
- blk_y  out  10  current block row
- haveLeft  out  1  to datapath; high when blk_x != 0
- haveAbove  out  1  to datapath; high when blk_y != 0
- w, h  out  10 each  to datapath; constant 4
- log2W, log2H  out  10 each  to datapath; constant 2
- nb_req  out  1  neighbour fetch request for (blk_x, blk_y); fetch unit holds leftCol/aboveRow stable while high
- nb_ack  in  1  one-cycle pulse: neighbour data valid at datapath inputs
- pb_valid  out  1  datapath `pred` is valid for (blk_x, blk_y)
- pb_ready  in  1  prediction buffer accepts block

## Operation
- States: IDLE, FETCH, PREDICT, WRITE, ADVANCE, DONE.
- IDLE: blk_x = blk_y = 0. On start=1, go to FETCH.
- FETCH:
  - If haveLeft|haveAbove: nb_req=1; wait for nb_ack, then go to PREDICT.
  - Else (block 0,0): nb_req stays 0 and the state goes straight to PREDICT next cycle; the datapath outputs mid-grey 128.
- PREDICT: load lat_cnt = PRED_LAT on entry, decrement each cycle; at lat_cnt = 1, go to WRITE. nb_req is held from FETCH.
- WRITE: pb_valid=1 until the cycle with pb_valid & pb_ready. On that cycle, go to ADVANCE, and nb_req and pb_valid drop the following cycle.
- ADVANCE: one cycle.
  - If blk_x = FRAME_W_BLK-1: blk_x <= 0 and blk_y <= blk_y+1; otherwise blk_x <= blk_x+1.
  - If the block was the last (blk_x = FRAME_W_BLK-1 and blk_y = FRAME_H_BLK-1), go to DONE instead and leave the coordinates unchanged.
- DONE: done=1 for one cycle, then IDLE, where the coordinates clear to 0.
- haveLeft, haveAbove, blk_x and blk_y are registered and change only in ADVANCE/IDLE. They are stable from FETCH entry through the WRITE handshake.
- Boundary conditions:
  - nb_ack outside FETCH is ignored.
  - start outside IDLE is ignored.
  - pb_ready without pb_valid has no effect.
  - FRAME_W_BLK = 1: every block has haveLeft = 0.
  - FRAME_H_BLK = 1: every block has haveAbove = 0.
  - Coordinate counters never exceed FRAME_*_BLK-1; no wrap beyond the frame.
- Reset (any state, including mid-frame): next state IDLE, all outputs at reset values, lat_cnt = 0, in-flight block discarded.

## Timing
- Reset values:
  - busy, done, nb_req, pb_valid, haveLeft, haveAbove = 0; blk_x = blk_y = 0.
  - w = h = 4 and log2W = log2H = 2 (constants, also during reset).
- start sampled in cycle T: busy=1 and state FETCH in T+1.
- Block (0,0), no stalls: FETCH 1 cycle, PREDICT PRED_LAT cycles, WRITE ≥1 cycle, ADVANCE 1 cycle, for 3+PRED_LAT cycles per block.
- Other blocks: FETCH lasts until nb_ack (minimum 1 cycle if nb_ack arrives in the first FETCH cycle), with the same minimum of 3+PRED_LAT cycles per block.
- Frame minimum, no stalls: FRAME_W_BLK·FRAME_H_BLK·(3+PRED_LAT)+1 cycles from start to done. The done cycle replaces the last ADVANCE's coordinate update.
- pb_valid rises the cycle after PREDICT completes and stays high with constant coordinates until accepted.
- done occurs 2 cycles after the final handshake cycle (ADVANCE, then DONE); busy drops in the cycle after done.

## Test plan
- 2x2 frame, PRED_LAT=1, nb_ack immediate, pb_ready=1 -> blocks written in order (0,0),(1,0),(0,1),(1,1) with haveLeft/haveAbove = 00,10,01,11; nb_req stays 0 for (0,0); done 17 cycles after start.
- 1x1 frame -> one write with haveLeft=haveAbove=0 and no nb_req; done at start+5; busy low at start+6.
- nb_ack delayed 7 cycles on block (1,0) -> FETCH holds with nb_req=1; pb_valid rises exactly PRED_LAT+1 cycles after nb_ack; coordinates unchanged throughout.
- pb_ready low for 5 cycles on block (0,1) -> pb_valid, nb_req and coordinates held for 6 cycles; exactly one acceptance; no skipped or duplicated block.
- rst asserted during PREDICT of block (1,1) in a 4x4 frame -> next cycle IDLE, all outputs at reset values; a following start restarts from (0,0).
- start pulses while busy, stray nb_ack in PREDICT/WRITE, stray pb_ready in FETCH -> no effect on sequence, coordinates or done count.
